// File: rtl/stage_ifetch.sv
// stage_ifetch: instruction fetch stage feeding decode.
// Walks a PC through synchronous program memory (1-cycle read latency), buffers
// returned bytes in a 2-entry FIFO and presents the head to decode each cycle.
// A returned 8'h00 marks end of program and halts fetch; a redirect from the
// execute stage reloads the PC and flushes everything buffered.
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   mem_addr, mem_en  program memory read address (= pc) and read strobe
//   mem_data          read data, valid the cycle after mem_en
//   opcode            FIFO head to decode, 8'h00 when nothing is ready
//   ack               decode consumed opcode this cycle
//   redirect(_pc)     load PC and flush the stage
//   halted            end-of-program byte fetched
module stage_ifetch #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  input  logic [7:0]            mem_data,
  output logic [7:0]            opcode,
  input  logic                  ack,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  halted
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 2;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]         head_q, head_d;
  logic [DW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic                  squash_q, squash_d;
  logic                  halted_q, halted_d;

  logic                  pop;
  logic                  ret;
  logic                  push;
  logic                  issue;
  logic [CW:0]           occ;

  // Handshake decode: what leaves, what arrives, whether a new read fits.
  always_comb begin
    pop   = ack && (count_q != CW'(0)) && !redirect;
    // A returning byte counts only if not squashed, not halted and not flushed now.
    ret   = inflight_q && !squash_q && !halted_q && !redirect;
    push  = ret && (mem_data != DW'(0));
    // Buffered plus outstanding bytes after this cycle's pop must leave room.
    occ   = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    issue = reset && !redirect && !halted_q && (occ < (CW+1)'(2));
  end

  assign mem_en   = issue;
  assign mem_addr = pc_q;
  assign opcode   = (count_q != CW'(0) && !redirect) ? head_q : DW'(0);
  assign halted   = halted_q;

  // Next-state for PC, FIFO and status flags.
  always_comb begin
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = issue;
    squash_d   = 1'b0;
    halted_d   = halted_q;
    if (redirect) begin
      count_d  = CW'(0);
      pc_d     = redirect_pc;
      squash_d = inflight_q;
      halted_d = 1'b0;
    end else begin
      if (pop) begin
        head_d  = tail_q;
        count_d = count_q - CW'(1);
      end
      // Push after pop so simultaneous push/pop keeps FIFO order.
      if (push) begin
        if (count_d == CW'(0)) begin
          head_d = mem_data;
        end else begin
          tail_d = mem_data;
        end
        count_d = count_d + CW'(1);
      end
      if (ret && (mem_data == DW'(0))) begin
        halted_d = 1'b1;
      end
      if (issue) begin
        pc_d = pc_q + ADDR_WIDTH'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
      halted_q   <= halted_d;
    end
  end

  // FIFO occupancy can never exceed its two entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (count_q <= CW'(2)) else $error("stage_ifetch FIFO count overflow");
    end
  end

endmodule

// File: tb/tb_stage_ifetch.sv
// tb_stage_ifetch: directed scenarios plus randomized traffic for stage_ifetch,
// compared cycle by cycle against a queue-based model of the fetch stage.
module tb_stage_ifetch;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 4096;

  logic          clk;
  logic          reset;
  logic [AW-1:0] mem_addr;
  logic          mem_en;
  logic [7:0]    mem_data;
  logic [7:0]    opcode;
  logic          ack;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          halted;

  logic [7:0]    mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: buffered bytes, outstanding read, pc, halt flag.
  logic [7:0] m_q[$];
  bit         m_pend;
  int         m_paddr;
  int         m_pc;
  bit         m_halted;
  bit         m_known;
  logic [7:0] consumed[$];

  stage_ifetch #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_en      (mem_en),
    .mem_data    (mem_data),
    .opcode      (opcode),
    .ack         (ack),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous program memory, one cycle read latency.
  always @(posedge clk) begin
    if (mem_en) mem_data <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against model, advance model.
  task automatic step(input bit rst, input bit a, input bit rd, input int rpc);
    bit         pop;
    bit         en;
    int         occ;
    logic [7:0] eop;
    logic [7:0] b;
    @(negedge clk);
    reset       = rst;
    ack         = a;
    redirect    = rd;
    redirect_pc = AW'(rpc);
    #1;
    pop = 1'b0;
    en  = 1'b0;
    if (m_known) begin
      eop = (rd || m_q.size() == 0) ? 8'h00 : m_q[0];
      pop = a && (m_q.size() != 0) && !rd;
      occ = m_q.size() + int'(m_pend) - int'(pop);
      en  = rst && !rd && !m_halted && (occ < 2);
      chk("opcode",   32'(opcode),   32'(eop));
      chk("mem_en",   32'(mem_en),   32'(en));
      chk("mem_addr", 32'(mem_addr), 32'(m_pc));
      chk("halted",   32'(halted),   32'(m_halted));
      if (a && opcode != 8'h00) consumed.push_back(opcode);
    end
    if (!rst) begin
      m_q.delete();
      m_pend   = 1'b0;
      m_pc     = 0;
      m_halted = 1'b0;
      m_known  = 1'b1;
    end else if (m_known) begin
      if (rd) begin
        m_q.delete();
        m_pend   = 1'b0;
        m_halted = 1'b0;
        m_pc     = rpc % DEPTH;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_pend && !m_halted) begin
          b = mem[m_paddr];
          if (b == 8'h00) m_halted = 1'b1;
          else            m_q.push_back(b);
        end
        m_pend  = en;
        m_paddr = m_pc;
        if (en) m_pc = (m_pc + 1) % DEPTH;
      end
    end
  endtask

  task automatic expect_seq(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_len"}, 32'(consumed.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < consumed.size(); i++)
      chk(tag, 32'(consumed[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] exp[$];
    reset = 1'b0; ack = 1'b0; redirect = 1'b0; redirect_pc = '0;
    m_known = 1'b0; m_pend = 1'b0; m_pc = 0; m_halted = 1'b0; m_paddr = 0;

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h11;
    mem[0] = 8'h2B; mem[1] = 8'h3E; mem[2] = 8'h2D; mem[3] = 8'h3C; mem[4] = 8'h00;
    mem[5] = 8'h41; mem[6] = 8'h42; mem[7] = 8'h43; mem[8] = 8'h00;
    for (int i = 0; i < 32; i++) mem[32 + i] = 8'(8'h60 + i);
    mem[64] = 8'h00;
    mem[4093] = 8'hA1; mem[4094] = 8'hA2; mem[4095] = 8'hA3;

    // Program "+>-<" then end marker, ack held high.
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    consumed.delete();
    repeat (12) step(1, 1, 0, 0);
    exp = '{8'h2B, 8'h3E, 8'h2D, 8'h3C};
    expect_seq("t1_seq", exp);
    chk("t1_halted", 32'(halted), 32'h1);
    chk("t1_mem_en", 32'(mem_en), 32'h0);

    // Redirect while halted resumes at redirect target.
    consumed.delete();
    step(1, 1, 1, 5);
    chk("t5_halted", 32'(halted), 32'h1);
    repeat (10) step(1, 1, 0, 0);
    exp = '{8'h41, 8'h42, 8'h43};
    expect_seq("t5_seq", exp);

    // Backpressure: ack low for 10 cycles mid-stream.
    consumed.delete();
    step(1, 1, 1, 32);
    repeat (6) step(1, 1, 0, 0);
    repeat (10) step(1, 0, 0, 0);
    repeat (40) step(1, 1, 0, 0);
    exp.delete();
    for (int i = 0; i < 32; i++) exp.push_back(8'(8'h60 + i));
    expect_seq("t2_seq", exp);

    // Redirect with a read in flight: stale byte dropped.
    consumed.delete();
    step(1, 1, 1, 32);
    repeat (5) step(1, 1, 0, 0);
    consumed.delete();
    step(1, 1, 1, 5);
    repeat (10) step(1, 1, 0, 0);
    exp = '{8'h41, 8'h42, 8'h43};
    expect_seq("t3_seq", exp);

    // PC wraps from the top of memory back to address 0.
    consumed.delete();
    step(1, 1, 1, 4093);
    repeat (14) step(1, 1, 0, 0);
    exp = '{8'hA1, 8'hA2, 8'hA3, 8'h2B, 8'h3E, 8'h2D, 8'h3C};
    expect_seq("t4_seq", exp);

    // Reset beats a simultaneous redirect.
    step(1, 1, 1, 32);
    repeat (4) step(1, 1, 0, 0);
    step(0, 1, 1, 50);
    step(0, 1, 0, 0);
    chk("t6_mem_en", 32'(mem_en), 32'h0);
    chk("t6_addr",   32'(mem_addr), 32'h0);
    chk("t6_opcode", 32'(opcode), 32'h0);
    for (int i = 0; i < DEPTH; i++)
      mem[i] = ($urandom_range(0, 19) == 0) ? 8'h00 : 8'($urandom_range(1, 255));

    // Randomized ack/redirect/reset traffic.
    for (int n = 0; n < 4000; n++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 24) == 0),
           int'($urandom_range(0, DEPTH - 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
